control_sequencer: RTL and testbench

//  Hardwired control unit that drives every select/enable input of ALUSystem. Fetches 16-bit instructions

---
 rtl/control_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit driving every ALUSystem select/enable.
// Optional CU_SINGLE_STEP_EN adds a STEP input and a WAIT_STEP state between instructions.
module control_sequencer #(
    parameter int MEM_WAIT     = 0,
    parameter bit CLEAR_RF_RST = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET_N,
`ifdef CU_SINGLE_STEP_EN
    input  logic        STEP,
`endif
    input  logic [15:0] IR_Out,
    input  logic [3:0]  ALU_Flag,
    output logic [1:0]  RF_OutASel,
    output logic [1:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        INSTR_DONE,
    output logic        HALTED
);

    localparam int WW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_WAIT);

    typedef enum logic [2:0] {
        S_INIT,
        S_FETCH_L,
        S_FETCH_H,
        S_EXEC0,
        S_EXEC1,
`ifdef CU_SINGLE_STEP_EN
        S_WAIT_STEP,
`endif
        S_HALT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    state_t        w_after;
    logic [WW-1:0] r_wait;
    logic          r_z;

    logic [3:0] w_opc;
    logic [1:0] w_rd;
    logic [1:0] w_rs1;
    logic [1:0] w_rs2;
    logic [3:0] w_rd_en;
    logic [3:0] w_alu_fun;
    logic       w_mem;
    logic       w_last;
    logic       w_mem_op;
    logic       w_alu_op;
    logic       w_unused;

    assign w_opc    = IR_Out[15:12];
    assign w_rd     = IR_Out[11:10];
    assign w_rs1    = IR_Out[9:8];
    assign w_rs2    = IR_Out[7:6];
    assign w_rd_en  = ~(4'b1000 >> w_rd);
    assign w_mem    = (r_state == S_FETCH_L) || (r_state == S_FETCH_H) ||
                      (r_state == S_EXEC1);
    assign w_last   = (r_wait == WAIT_MAX);
    assign w_mem_op = (w_opc == 4'h0) || (w_opc == 4'h1);
    assign w_alu_op = (w_opc >= 4'h4) && (w_opc <= 4'hB);
    assign w_unused = ^{IR_Out[5:0], ALU_Flag[2:0]};

`ifdef CU_SINGLE_STEP_EN
    assign w_after = S_WAIT_STEP;
`else
    assign w_after = S_FETCH_L;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_INIT;
            r_wait  <= '0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_mem && !w_last) r_wait <= r_wait + 1'b1;
            else                  r_wait <= '0;
            if (r_state == S_EXEC0 && w_alu_op) r_z <= ALU_Flag[3];
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_INIT:    w_next = S_FETCH_L;
            S_FETCH_L: if (w_last) w_next = S_FETCH_H;
            S_FETCH_H: if (w_last) w_next = S_EXEC0;
            S_EXEC0: begin
                unique case (1'b1)
                    w_mem_op:         w_next = S_EXEC1;
                    (w_opc == 4'hF):  w_next = S_HALT;
                    default:          w_next = w_after;
                endcase
            end
            S_EXEC1:   if (w_last) w_next = w_after;
`ifdef CU_SINGLE_STEP_EN
            S_WAIT_STEP: if (STEP) w_next = S_FETCH_L;
`endif
            default:   w_next = r_state;
        endcase
    end

    always_comb begin
        w_alu_fun = 4'b0000;
        case (w_opc)
            4'h4:    w_alu_fun = 4'b0100;
            4'h5:    w_alu_fun = 4'b0110;
            4'h6:    w_alu_fun = 4'b0111;
            4'h7:    w_alu_fun = 4'b1000;
            4'h8:    w_alu_fun = 4'b1001;
            4'h9:    w_alu_fun = 4'b0010;
            4'hA:    w_alu_fun = 4'b1010;
            4'hB:    w_alu_fun = 4'b1011;
            default: w_alu_fun = 4'b0000;
        endcase
    end

    // Idle set first; reset low keeps it regardless of state.
    always_comb begin
        RF_OutASel  = 2'b00;
        RF_OutBSel  = 2'b00;
        RF_FunSel   = 2'b00;
        RF_RegSel   = 4'b1111;
        ALU_FunSel  = 4'b0000;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 2'b00;
        ARF_RegSel  = 3'b111;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        IR_Funsel   = 2'b00;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;
        INSTR_DONE  = 1'b0;
        HALTED      = 1'b0;
        if (RESET_N) begin
            unique case (r_state)
                S_INIT: begin
                    ARF_FunSel = 2'b11;
                    ARF_RegSel = 3'b000;
                    if (CLEAR_RF_RST) begin
                        RF_FunSel = 2'b11;
                        RF_RegSel = 4'b0000;
                    end
                end
                S_FETCH_L, S_FETCH_H: begin
                    Mem_CS = 1'b0;
                    IR_LH  = (r_state == S_FETCH_H);
                    if (w_last) begin
                        IR_Enable  = 1'b1;
                        IR_Funsel  = 2'b10;
                        ARF_FunSel = 2'b01;
                        ARF_RegSel = 3'b011;
                    end
                end
                S_EXEC0: begin
                    INSTR_DONE = !w_mem_op;
                    unique case (1'b1)
                        w_mem_op: begin
                            MuxBSel    = 2'b01;
                            ARF_FunSel = 2'b10;
                            ARF_RegSel = 3'b101;
                        end
                        (w_opc == 4'h2): begin
                            MuxASel   = 2'b00;
                            RF_FunSel = 2'b10;
                            RF_RegSel = w_rd_en;
                        end
                        (w_opc == 4'h3): begin
                            RF_OutASel = w_rs1;
                            MuxCSel    = 1'b1;
                            MuxASel    = 2'b11;
                            RF_FunSel  = 2'b10;
                            RF_RegSel  = w_rd_en;
                        end
                        w_alu_op: begin
                            RF_OutASel = w_rs1;
                            RF_OutBSel = w_rs2;
                            ALU_FunSel = w_alu_fun;
                            MuxASel    = 2'b11;
                            RF_FunSel  = 2'b10;
                            RF_RegSel  = w_rd_en;
                        end
                        (w_opc == 4'hC) || (w_opc == 4'hD): begin
                            RF_FunSel = (w_opc == 4'hC) ? 2'b01 : 2'b00;
                            RF_RegSel = w_rd_en;
                        end
                        (w_opc == 4'hE): begin
                            if (r_z) begin
                                MuxBSel    = 2'b01;
                                ARF_FunSel = 2'b10;
                                ARF_RegSel = 3'b011;
                            end
                        end
                        default: ;
                    endcase
                end
                S_EXEC1: begin
                    ARF_OutDSel = 2'b10;
                    Mem_CS      = 1'b0;
                    INSTR_DONE  = w_last;
                    if (w_opc == 4'h0) begin
                        MuxASel   = 2'b01;
                        RF_FunSel = 2'b10;
                        RF_RegSel = w_rd_en;
                    end else begin
                        RF_OutASel = w_rd;
                        MuxCSel    = 1'b1;
                        Mem_WR     = w_last;
                    end
                end
                S_HALT: HALTED = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random instruction stream against a per-instruction
// cycle-script reference model; a second MEM_WAIT=0 / no-RF-clear instance is spot-checked.
module tb_control_sequencer;

    localparam int MW = 2;
`ifdef CU_SINGLE_STEP_EN
    localparam int SS = 1;
`else
    localparam int SS = 0;
`endif

    typedef struct packed {
        logic [1:0] oa;
        logic [1:0] ob;
        logic [1:0] rff;
        logic [3:0] rrs;
        logic [3:0] alu;
        logic [1:0] oc;
        logic [1:0] od;
        logic [1:0] aff;
        logic [2:0] ars;
        logic       lh;
        logic       ire;
        logic [1:0] irf;
        logic       wr;
        logic       cs;
        logic [1:0] ma;
        logic [1:0] mb;
        logic       mc;
        logic       done;
        logic       halt;
    } cw_t;

    typedef struct {
        cw_t w;
        bit  zl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        step = 1'b1;
    logic [15:0] ir = 16'h2005;
    logic [3:0]  flag = 4'h0;
    wire  [35:0] v;
    wire  [35:0] v0;
    cw_t         obs;
    cw_t         obs0;
    exp_t        q[$];
    bit          z_m;
    bit          chk0;
    int          since_rel;
    int          n_cmp;
    int          n_bad;

    assign obs  = v;
    assign obs0 = v0;

    always #5 clk = ~clk;

    control_sequencer #(.MEM_WAIT(MW), .CLEAR_RF_RST(1'b1)) u_dut (
        .CLK(clk), .RESET_N(rst_n),
`ifdef CU_SINGLE_STEP_EN
        .STEP(step),
`endif
        .IR_Out(ir), .ALU_Flag(flag),
        .RF_OutASel(v[35:34]), .RF_OutBSel(v[33:32]), .RF_FunSel(v[31:30]),
        .RF_RegSel(v[29:26]), .ALU_FunSel(v[25:22]), .ARF_OutCSel(v[21:20]),
        .ARF_OutDSel(v[19:18]), .ARF_FunSel(v[17:16]), .ARF_RegSel(v[15:13]),
        .IR_LH(v[12]), .IR_Enable(v[11]), .IR_Funsel(v[10:9]),
        .Mem_WR(v[8]), .Mem_CS(v[7]), .MuxASel(v[6:5]), .MuxBSel(v[4:3]),
        .MuxCSel(v[2]), .INSTR_DONE(v[1]), .HALTED(v[0])
    );

    control_sequencer #(.MEM_WAIT(0), .CLEAR_RF_RST(1'b0)) u_dut0 (
        .CLK(clk), .RESET_N(rst_n),
`ifdef CU_SINGLE_STEP_EN
        .STEP(step),
`endif
        .IR_Out(ir), .ALU_Flag(flag),
        .RF_OutASel(v0[35:34]), .RF_OutBSel(v0[33:32]), .RF_FunSel(v0[31:30]),
        .RF_RegSel(v0[29:26]), .ALU_FunSel(v0[25:22]), .ARF_OutCSel(v0[21:20]),
        .ARF_OutDSel(v0[19:18]), .ARF_FunSel(v0[17:16]), .ARF_RegSel(v0[15:13]),
        .IR_LH(v0[12]), .IR_Enable(v0[11]), .IR_Funsel(v0[10:9]),
        .Mem_WR(v0[8]), .Mem_CS(v0[7]), .MuxASel(v0[6:5]), .MuxBSel(v0[4:3]),
        .MuxCSel(v0[2]), .INSTR_DONE(v0[1]), .HALTED(v0[0])
    );

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic cw_t idle();
        cw_t c = '0;
        c.rrs = 4'b1111;
        c.ars = 3'b111;
        c.cs  = 1'b1;
        return c;
    endfunction

    function automatic cw_t init_w(input bit clr);
        cw_t c = idle();
        c.aff = 2'b11;
        c.ars = 3'b000;
        if (clr) begin
            c.rff = 2'b11;
            c.rrs = 4'b0000;
        end
        return c;
    endfunction

    function automatic logic [3:0] reg_en(input logic [1:0] r);
        logic [3:0] m = 4'b1111;
        m[3 - int'(r)] = 1'b0;
        return m;
    endfunction

    function automatic logic [3:0] alu_code(input logic [3:0] op);
        logic [3:0] tab [16];
        tab = '{4'h0, 4'h0, 4'h0, 4'h0, 4'b0100, 4'b0110, 4'b0111, 4'b1000,
                4'b1001, 4'b0010, 4'b1010, 4'b1011, 4'h0, 4'h0, 4'h0, 4'h0};
        return tab[op];
    endfunction

    task automatic push(input cw_t c, input bit zl);
        exp_t e;
        e.w  = c;
        e.zl = zl;
        q.push_back(e);
    endtask

    // Expected control words, one per cycle, for a whole instruction.
    task automatic build(input logic [15:0] i);
        cw_t        c;
        logic [3:0] op  = i[15:12];
        logic [1:0] rd  = i[11:10];
        logic [1:0] rs1 = i[9:8];
        logic [1:0] rs2 = i[7:6];
        for (int h = 0; h < 2; h++) begin
            for (int w = 0; w <= MW; w++) begin
                c = idle();
                c.cs = 1'b0;
                c.lh = h[0];
                if (w == MW) begin
                    c.ire = 1'b1;
                    c.irf = 2'b10;
                    c.aff = 2'b01;
                    c.ars = 3'b011;
                end
                push(c, 1'b0);
            end
        end
        c = idle();
        c.done = 1'b1;
        if (op <= 4'h1) begin
            c.done = 1'b0;
            c.mb  = 2'b01;
            c.aff = 2'b10;
            c.ars = 3'b101;
            push(c, 1'b0);
            for (int w = 0; w <= MW; w++) begin
                c = idle();
                c.od = 2'b10;
                c.cs = 1'b0;
                c.done = (w == MW);
                if (op == 4'h0) begin
                    c.ma  = 2'b01;
                    c.rff = 2'b10;
                    c.rrs = reg_en(rd);
                end else begin
                    c.oa = rd;
                    c.mc = 1'b1;
                    c.wr = (w == MW);
                end
                push(c, 1'b0);
            end
        end else if (op == 4'h2) begin
            c.rff = 2'b10;
            c.rrs = reg_en(rd);
            push(c, 1'b0);
        end else if (op == 4'h3) begin
            c.oa  = rs1;
            c.mc  = 1'b1;
            c.ma  = 2'b11;
            c.rff = 2'b10;
            c.rrs = reg_en(rd);
            push(c, 1'b0);
        end else if (op <= 4'hB) begin
            c.oa  = rs1;
            c.ob  = rs2;
            c.alu = alu_code(op);
            c.ma  = 2'b11;
            c.rff = 2'b10;
            c.rrs = reg_en(rd);
            push(c, 1'b1);
        end else if (op <= 4'hD) begin
            c.rff = (op == 4'hC) ? 2'b01 : 2'b00;
            c.rrs = reg_en(rd);
            push(c, 1'b0);
        end else if (op == 4'hE) begin
            if (z_m) begin
                c.mb  = 2'b01;
                c.aff = 2'b10;
                c.ars = 3'b011;
            end
            push(c, 1'b0);
        end else begin
            push(c, 1'b0);
            c = idle();
            c.halt = 1'b1;
            for (int k = 0; k < 20; k++) push(c, 1'b0);
        end
        if (op != 4'hF && SS == 1) push(idle(), 1'b0);
    endtask

    task automatic step_one(input bit set_ir, input logic [15:0] i);
        exp_t e;
        cw_t  c;
        @(negedge clk);
        if (set_ir) ir = i;
        since_rel++;
        e = q.pop_front();
        chk("cw", obs, e.w);
        if (chk0 && since_rel == 4) begin
            c = idle();
            c.rff  = 2'b10;
            c.rrs  = 4'b0111;
            c.done = 1'b1;
            chk("ldi_mw0", obs0, c);
            chk0 = 1'b0;
        end
        flag = 4'($urandom);
        if (e.zl) z_m = flag[3];
    endtask

    task automatic run_instr(input logic [15:0] i);
        bit first = 1'b1;
        build(i);
        while (q.size() > 0) begin
            step_one(first, i);
            first = 1'b0;
        end
    endtask

    task automatic do_reset(input bit first_time);
        rst_n = 1'b0;
        z_m   = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_idle", obs, idle());
        if (first_time) chk("rst_idle0", obs0, idle());
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        since_rel = 1;
        chk("init", obs, init_w(1'b1));
        if (first_time) chk("init_noclr", obs0, init_w(1'b0));
    endtask

    task automatic st_reset();
        bit first = 1'b1;
        build(16'h1880);
        while (q.size() > 1 + SS) begin
            step_one(first, 16'h1880);
            first = 1'b0;
        end
        @(posedge clk);
        #2;
        chk("st_wr", 36'(obs.wr), 36'd1);
        chk("st_cs", 36'(obs.cs), 36'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_cs", 36'(obs.cs), 36'd1);
        chk("rst_wr", 36'(obs.wr), 36'd0);
        chk("rst_all", obs, idle());
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        chk0  = 1'b1;
        do_reset(1'b1);
        run_instr(16'h2005);
        run_instr(16'h2400);
        run_instr(16'h4840);
        run_instr(16'hE010);
        for (int k = 0; k < 150; k++)
            run_instr({4'($urandom_range(0, 14)), 12'($urandom)});
        run_instr(16'hF000);
        do_reset(1'b0);
        st_reset();
        do_reset(1'b0);
        for (int k = 0; k < 100; k++)
            run_instr({4'($urandom_range(0, 14)), 12'($urandom)});
        run_instr(16'h4840);
        run_instr(16'hE010);
        run_instr(16'h1880);
        run_instr(16'h0C40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
